// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address and
// the IF/ID pipeline register, plus saturating stall/flush counters and sticky error flags.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             IF_ID_Write,
  input  logic             IF_Flush,
  input  logic [31:0]      ID_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      IF_ID_PC,
  output logic [31:0]      IF_ID_Instr,
  output logic             IF_ID_Valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0] pc;
  logic        misaligned;

  assign imem_addr  = pc;
  assign misaligned = (ID_target[1:0] != 2'b00);

  // A stalled PC drops any redirect requested in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (PCWrite) begin
      if (IF_Flush) begin
        pc <= {ID_target[31:2], 2'b00};
      end else begin
        pc <= pc + 32'd4;
      end
    end
  end

  // Flush overrides a held IF/ID so a bubble is always inserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      IF_ID_PC    <= RESET_PC;
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_Valid <= 1'b0;
    end else if (IF_Flush) begin
      IF_ID_PC    <= pc;
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_Valid <= 1'b0;
    end else if (IF_ID_Write) begin
      IF_ID_PC    <= pc;
      IF_ID_Instr <= imem_rdata;
      IF_ID_Valid <= 1'b1;
    end
  end

  // Saturating debug counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PCWrite && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (IF_Flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky protocol-error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 2'b00;
    end else begin
      if (IF_Flush && !PCWrite) begin
        err[0] <= 1'b1;
      end
      if (IF_Flush && PCWrite && misaligned) begin
        err[1] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a cycle-level reference model,
// preceded by a directed walk through the main fetch, stall and redirect scenarios.
module tb_if_stage;

  localparam int unsigned CNT_W = 3;
  localparam int          CMAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             reset;
  logic             pc_write;
  logic             if_id_write;
  logic             if_flush;
  logic [31:0]      id_target;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic [31:0]      if_id_pc;
  logic [31:0]      if_id_instr;
  logic             if_id_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       err;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] m_pc, m_ipc, m_instr;
  logic        m_valid;
  logic [1:0]  m_err;
  int          n_stall, n_flush;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .PCWrite(pc_write), .IF_ID_Write(if_id_write),
    .IF_Flush(if_flush), .ID_target(id_target), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .IF_ID_PC(if_id_pc), .IF_ID_Instr(if_id_instr),
    .IF_ID_Valid(if_id_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err(err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1357};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("imem_addr", imem_addr, m_pc);
    check("if_id_pc", if_id_pc, m_ipc);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    check("stall_cnt", 32'(stall_cnt), 32'(sat(n_stall)));
    check("flush_cnt", 32'(flush_cnt), 32'(sat(n_flush)));
    check("err", 32'(err), 32'(m_err));
  endtask

  // Drive one cycle of inputs, advance the model by the stated rules, compare after the edge.
  task automatic cycle(input logic r, input logic pw, input logic iw,
                       input logic fl, input logic [31:0] t);
    logic [31:0] nx_pc, nx_ipc, nx_instr;
    logic        nx_valid;
    reset = r; pc_write = pw; if_id_write = iw; if_flush = fl; id_target = t;
    nx_pc = m_pc; nx_ipc = m_ipc; nx_instr = m_instr; nx_valid = m_valid;
    if (r) begin
      nx_pc = RST_PC; nx_ipc = RST_PC; nx_instr = NOP; nx_valid = 1'b0;
      n_stall = 0; n_flush = 0; m_err = 2'b00;
    end else begin
      if (!pw) n_stall++;
      if (fl) n_flush++;
      if (fl && !pw) m_err[0] = 1'b1;
      if (fl && pw && (t % 4 != 0)) m_err[1] = 1'b1;
      if (fl) begin
        nx_ipc = m_pc; nx_instr = NOP; nx_valid = 1'b0;
      end else if (iw) begin
        nx_ipc = m_pc; nx_instr = mem_word(m_pc); nx_valid = 1'b1;
      end
      if (pw) nx_pc = fl ? (t & ~32'd3) : m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    m_pc = nx_pc; m_ipc = nx_ipc; m_instr = nx_instr; m_valid = nx_valid;
    check_all();
  endtask

  initial begin
    m_pc = 'x; m_ipc = 'x; m_instr = 'x; m_valid = 'x; m_err = 'x;
    n_stall = 0; n_flush = 0;
    cycle(1, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(if_id_valid), 32'h0);

    // Free run.
    cycle(0, 1, 1, 0, 0);
    check("fetch0", if_id_instr, 32'h00A0_0093);
    cycle(0, 1, 1, 0, 0);
    check("fetch4", if_id_instr, 32'h0010_0113);
    check("addr8", imem_addr, 32'h8);

    // Stall two cycles at PC=8.
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("stall_addr", imem_addr, 32'h8);
    check("stall_ifid_pc", if_id_pc, 32'h4);
    check("stall_cnt2", 32'(stall_cnt), 32'd2);
    cycle(0, 1, 1, 0, 0);
    check("resume_addr", imem_addr, 32'hC);

    // Redirect to 0x40.
    cycle(0, 1, 1, 1, 32'h40);
    check("redir_addr", imem_addr, 32'h40);
    check("redir_instr", if_id_instr, NOP);
    check("flush_cnt1", 32'(flush_cnt), 32'd1);
    cycle(0, 1, 1, 0, 0);
    check("redir_ifid_pc", if_id_pc, 32'h40);
    check("redir_valid", 32'(if_id_valid), 32'h1);

    // Misaligned redirect.
    cycle(0, 1, 1, 1, 32'h42);
    check("mis_addr", imem_addr, 32'h40);
    check("mis_err", 32'(err), 32'h2);

    // Flush while PC stalled.
    cycle(0, 0, 1, 1, 32'h80);
    check("proto_addr", imem_addr, 32'h40);
    check("proto_err", 32'(err), 32'h3);

    // Wrap at top of address space.
    cycle(0, 1, 1, 1, 32'hFFFF_FFFC);
    cycle(0, 1, 1, 0, 0);
    check("wrap_addr", imem_addr, 32'h0);

    // Saturation, then reset in the middle of a stall.
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
    check("stall_sat", 32'(stall_cnt), 32'(CMAX));
    cycle(1, 0, 0, 1, 32'h44);
    check("midrst_addr", imem_addr, RST_PC);
    check("midrst_err", 32'(err), 32'h0);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      logic r, pw, iw, fl;
      logic [31:0] t;
      r  = ($urandom_range(0, 59) == 0);
      pw = ($urandom_range(0, 3) != 0);
      iw = ($urandom_range(0, 4) == 0) ? ~pw : pw;
      fl = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0:       t = 32'hFFFF_FFFC;
        1:       t = $urandom & 32'h0000_00FF;
        default: t = $urandom;
      endcase
      cycle(r, pw, iw, fl, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
